// File: rtl/trig_capture_ctrl.sv
// Capture sequencer for the logic analyzer sample RAM: fills a circular buffer,
// qualifies the trigger once enough pre-trigger history exists, then freezes after the post-trigger window.
module trig_capture_ctrl #(
    parameter int DEPTH  = 384,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              protTrig,
    input  logic              ch_trig,
    input  logic              capture_en,
    input  logic              wrt_smpl,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] rd_start
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    // One extra bit so the pre-fill target can reach DEPTH when the post window is zero.
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_start_q, rd_start_d;
    logic [ADDR_W-1:0] tp_eff_q, tp_eff_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0]  smpl_cnt_q, smpl_cnt_d;
    logic              pending_q, pending_d;

    logic              trig_in;
    logic              active;
    logic [ADDR_W-1:0] waddr_inc;
    logic [ADDR_W-1:0] post_cnt_inc;
    logic [CNT_W-1:0]  smpl_cnt_inc;
    logic [CNT_W-1:0]  arm_cnt;

    assign trig_in      = protTrig & ch_trig;
    assign active       = state_q inside {S_PRE, S_ARMED, S_POST};
    assign we           = wrt_smpl & capture_en & active;
    assign waddr_inc    = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
    assign post_cnt_inc = post_cnt_q + 1'b1;
    assign smpl_cnt_inc = smpl_cnt_q + 1'b1;
    assign arm_cnt      = DEPTH_C - {1'b0, tp_eff_q};

    // NOTE: every variable gets its hold value before the case so no branch can infer a latch.
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        trig_addr_d = trig_addr_q;
        rd_start_d  = rd_start_q;
        tp_eff_d    = tp_eff_q;
        post_cnt_d  = post_cnt_q;
        smpl_cnt_d  = smpl_cnt_q;
        pending_d   = pending_q;

        unique case (state_q)
            S_IDLE: begin
                if (capture_en) begin
                    state_d    = S_PRE;
                    waddr_d    = '0;
                    smpl_cnt_d = '0;
                    post_cnt_d = '0;
                    pending_d  = 1'b0;
                    tp_eff_d   = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;
                end
            end
            S_PRE: begin
                if (!capture_en) begin
                    state_d = S_IDLE;
                end else if (wrt_smpl) begin
                    waddr_d    = waddr_inc;
                    smpl_cnt_d = smpl_cnt_inc;
                    if (smpl_cnt_inc == arm_cnt) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!capture_en) begin
                    state_d = S_IDLE;
                end else if (wrt_smpl && (trig_in || pending_q)) begin
                    // This strobe's sample is the trigger sample.
                    waddr_d     = waddr_inc;
                    trig_addr_d = waddr_q;
                    post_cnt_d  = '0;
                    pending_d   = 1'b0;
                    if (tp_eff_q == '0) begin
                        state_d    = S_DONE;
                        rd_start_d = waddr_inc;
                    end else begin
                        state_d = S_POST;
                    end
                end else begin
                    if (wrt_smpl) waddr_d = waddr_inc;
                    if (trig_in) pending_d = 1'b1;
                end
            end
            S_POST: begin
                if (!capture_en) begin
                    state_d = S_IDLE;
                end else if (wrt_smpl) begin
                    waddr_d    = waddr_inc;
                    post_cnt_d = post_cnt_inc;
                    if (post_cnt_inc == tp_eff_q) begin
                        state_d    = S_DONE;
                        rd_start_d = waddr_inc;
                    end
                end
            end
            S_DONE: begin
                if (clr_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            rd_start_q  <= '0;
            tp_eff_q    <= '0;
            post_cnt_q  <= '0;
            smpl_cnt_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            trig_addr_q <= trig_addr_d;
            rd_start_q  <= rd_start_d;
            tp_eff_q    <= tp_eff_d;
            post_cnt_q  <= post_cnt_d;
            smpl_cnt_q  <= smpl_cnt_d;
            pending_q   <= pending_d;
        end
    end

    assign waddr        = waddr_q;
    assign trig_addr    = trig_addr_q;
    assign rd_start     = rd_start_q;
    assign armed        = (state_q == S_ARMED);
    assign triggered    = (state_q == S_POST) || (state_q == S_DONE);
    assign capture_done = (state_q == S_DONE);

endmodule

// File: doc/trig_capture_ctrl.md
Name: trig_capture_ctrl

Overview:
- Consumes protTrig, the protocol trigger, plus the combined channel trigger, and runs the capture state machine for the logic analyzer sample RAM.
- Writes samples into a circular buffer and holds off triggering until enough pre-trigger samples exist.
- After a trigger, counts trig_pos post-trigger samples, then freezes the buffer and reports the trigger and oldest-sample addresses to the readout path.

Parameters:
DEPTH, 384, number of sample RAM entries. Need not be a power of two; wrap is explicit at DEPTH-1.
ADDR_W, 9, address and counter width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
protTrig  input  1  protocol trigger condition
ch_trig  input  1  combined channel trigger condition
capture_en  input  1  level; high requests and sustains a capture
wrt_smpl  input  1  single-cycle strobe: one sample is valid this cycle
trig_pos  input  ADDR_W  number of post-trigger samples
clr_done  input  1  acknowledges a completed capture
we  output  1  RAM write enable
waddr  output  ADDR_W  RAM write address
armed  output  1  pre-trigger fill satisfied; triggers now accepted
triggered  output  1  trigger has occurred in the current capture
capture_done  output  1  capture complete; buffer frozen
trig_addr  output  ADDR_W  RAM address of the trigger sample
rd_start  output  ADDR_W  address of the oldest valid sample

Behaviour:
- Reset: state=IDLE; waddr, trig_addr, rd_start, counters and the pending flag are 0; armed, triggered and capture_done are 0.
- Trigger qualifier: trig_in = protTrig & ch_trig.
- tp_eff = min(trig_pos, DEPTH-1), latched on IDLE->PRE and held for the whole capture.
- we = wrt_smpl & (state is PRE, ARMED or POST). we is combinational and has zero latency.
- On every write, waddr advances after the write: DEPTH-1 wraps to 0.
- IDLE:
  - we=0.
  - When capture_en=1: clear waddr, sample count, pending flag and triggered; go to PRE.
- PRE:
  - Each write increments the sample count.
  - After the write that brings the count to DEPTH-tp_eff, go to ARMED; armed=1 from the next cycle.
  - trig_in is ignored in PRE and is not latched.
- ARMED:
  - If trig_in=1 in any cycle, set the pending flag.
  - On a cycle with wrt_smpl=1 and (trig_in | pending), that sample is the trigger sample:
    - trig_addr <= current waddr; triggered <= 1; post count <= 0; pending cleared.
    - If tp_eff=0, go to DONE; otherwise go to POST.
  - A trigger with no strobe waits in pending for the next wrt_smpl.
- POST:
  - Each write increments the post count.
  - After the write that brings the post count to tp_eff, go to DONE.
  - trig_in is ignored.
- DONE:
  - capture_done=1, we=0, waddr frozen.
  - rd_start = waddr. The buffer always holds at least DEPTH samples, so the oldest sample sits at the frozen write pointer.
  - Stays in DONE regardless of capture_en until clr_done=1, then goes to IDLE.
  - On DONE->IDLE, capture_done, triggered and armed all clear.
- Abort: capture_en=0 in PRE, ARMED or POST -> IDLE on the next edge.
  - we drops in that same cycle.
  - capture_done is not asserted; triggered and armed clear.
- Simultaneous clr_done and capture_en in DONE: go to IDLE; a new capture starts on the following cycle if capture_en is still high.
- armed is high only in ARMED. triggered is high in POST and DONE.
- Asynchronous reset mid-capture returns all state to the reset values immediately.

Test Plan:
1. Reset: assert rst_n=0 with random inputs -> we=0, waddr=0, armed=0, triggered=0, capture_done=0.
2. Nominal capture:
   - Stimulus: trig_pos=100, capture_en=1, wrt_smpl every cycle, trig_in pulsed while waddr=300.
   - armed rises after 284 writes.
   - trig_addr=300.
   - Exactly 100 further writes at addresses 301..383 then 0..16.
   - capture_done=1 with waddr=rd_start=17.
3. Pending trigger: wrt_smpl every 4th cycle; single-cycle trig_in between strobes while armed -> trigger is taken on the next strobe; trig_addr = that strobe's waddr.
4. Boundaries:
   - trig_pos=0: DONE directly from ARMED with no post writes; waddr = trig_addr+1 mod 384.
   - trig_pos=500: clamps to 383; armed after exactly 1 write.
5. Early and late triggers:
   - trig_in held high in PRE: ignored until armed, then fires on the first armed strobe.
   - trig_in in POST: ignored.
   - Either input of trig_in low: no trigger.
6. Abort and restart:
   - Drop capture_en in POST -> IDLE, capture_done stays 0, triggered clears.
   - Re-raise capture_en -> waddr restarts at 0.
   - In DONE, clr_done=1 -> all flags clear next cycle.
